aes_subword_ise: RTL and testbench
==================================

# aes_subword_ise

Multi-cycle forward AES SubWord instruction-set extension for the HOKSTER ALU complex. It substitutes a 32-bit word through a single shared 8-bit forward S-box, one byte per clock. It optionally applies RotWord and an Rcon XOR for on-core key expansion. It is the encryption-direction companion to the inverse S-box extension, and follows the same sr pass-through and w write-back convention.

## Interface
No parameters.
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- op_rot  in  1  1 = key-expansion form (RotWord + Rcon); honoured only with macro
- word_in  in  32  source word; byte 0 = bits 7:0, byte 3 = bits 31:24
- rcon_in  in  8  round constant XORed into bits 31:24
- sr  in  8  status register in
- sr_out  out  8  status register out; combinational copy of sr
- result  out  32  substituted word (registered)
- busy  out  1  high while the operation is in flight
- w  out  1  one-cycle write-back strobe; result valid while high

## Operation
- States: IDLE, SUB, DONE; 2-bit byte counter cnt.
- IDLE, start=1 at a clock edge:
  - Latch the working word into result. This is word_in, or {word_in[23:0], word_in[31:24]} when op_rot=1 and the macro is enabled.
  - Latch op_rot and rcon_in.
  - Set cnt=0 and move to SUB.
- SUB, each edge:
  - result[8*cnt+7 : 8*cnt] <= S(result[8*cnt+7 : 8*cnt]), using the FIPS-197 forward S-box as a 256-entry LUT.
  - cnt increments.
  - On the edge with cnt=3: move to DONE. If the latched op_rot=1 (macro enabled), also XOR the latched rcon into result[31:24] in that same edge, after substitution.
- DONE: w=1 for exactly one cycle, then return to IDLE at the next edge.
- start is ignored in SUB and DONE; it is not queued.
- word_in and rcon_in may change after acceptance without effect.
- sr_out = sr at all times, independent of state and reset.

## Timing
- Reset values: state IDLE, cnt=0, result=32'h0, busy=0, w=0.
- Let the edge that accepts start be edge N.
  - busy is high after edges N through N+4 and drops after edge N+5.
  - Bytes 0..3 are substituted at edges N+1..N+4.
  - w is high during the cycle after edge N+4 only.
- Latency: 5 cycles from the start edge to w; initiation interval 6 cycles.
- A start held high continuously is re-accepted at edge N+6.
- result holds its value after DONE until the next accepted start.
- Reset asserted mid-operation: all outputs go to reset values immediately. No w is emitted for the aborted operation.
- Reset deasserted with start=1: start is accepted at the first edge after release.

## Configuration
- Macro AES_KEYEXP_EN.
- Defined:
  - op_rot=1 selects RotWord on latch and Rcon XOR into bits 31:24 at the SUB to DONE edge.
  - op_rot=0 gives plain SubWord.
- Undefined:
  - op_rot and rcon_in are ignored; ports remain present.
  - The rotate and XOR logic are not synthesized.
  - Every operation is plain SubWord.
- Cycle timing is identical in both builds.

## Test plan
- Reset: assert rst mid-SUB -> result=0, busy=0, w=0 immediately; no w afterwards. sr=8'hA5 -> sr_out=8'hA5 throughout.
- SubWord: word_in=32'h03020100, op_rot=0 -> w pulses 5 cycles after start with result=32'h7B777C63.
- Key expansion (AES_KEYEXP_EN defined): word_in=32'h09CF4F3C, op_rot=1, rcon_in=8'h01 -> result=32'h8B84EB01.
- Same stimulus with the macro undefined -> result=32'h018A84EB (plain SubWord, no rotate, no Rcon).
- Busy rejection: pulse start again at edges N+2 and N+5 with different data -> one w only, result from the first request; a start at N+6 is accepted.
- Exhaustive S-box sweep:
  - Run 64 SubWord operations covering all bytes 0x00..0xFF.
  - Each result byte must match FIPS-197.
  - Feeding each byte through the inverse S-box extension must return the original value.

Source files
------------

// File: rtl/aes_subword_ise.sv
// aes_subword_ise: multi-cycle forward AES SubWord extension for the HOKSTER
// ALU complex. A 32-bit word passes through one shared 8-bit forward S-box,
// one byte per clock (byte 0 first). The result is valid while w is high.
//
// Build option: define AES_KEYEXP_EN to enable the key-expansion form
// (op_rot=1: RotWord when the word is latched, Rcon XOR into bits 31:24 on
// the last substitution edge). Without it, op_rot and rcon_in are ignored and
// every operation is a plain SubWord. Cycle timing is the same in both builds.
//
// sr is passed straight through to sr_out, as in the inverse S-box companion.

module aes_subword_ise (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        op_rot,
   input  logic [31:0] word_in,
   input  logic [7:0]  rcon_in,
   input  logic [7:0]  sr,
   output logic [7:0]  sr_out,
   output logic [31:0] result,
   output logic        busy,
   output logic        w
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SUB  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // FIPS-197 forward S-box; entry 0 is the most significant byte.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   logic [1:0]  state;
   logic [1:0]  cnt;
   logic [7:0]  cur_byte;
   logic [7:0]  sub_byte;
   logic [31:0] sub_word;
   logic [31:0] next_word;
   logic [31:0] load_word;

`ifdef AES_KEYEXP_EN
   logic        rot_q;
   logic [7:0]  rcon_q;
`else
   // The key-expansion inputs stay on the port list but have no load here.
   logic        unused_keyexp;
   assign unused_keyexp = ^{op_rot, rcon_in};
`endif

   // Status register is a pure pass-through, untouched by reset or state.
   assign sr_out = sr;

   // Handshake outputs decode directly from the state register.
   assign busy = (state != ST_IDLE);
   assign w    = (state == ST_DONE);

   // Substitute the byte selected by cnt and form the next working word.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      cur_byte  = result[{cnt, 3'b000} +: 8];
      sub_byte  = SBOX[cur_byte];
      sub_word  = result;
      sub_word[{cnt, 3'b000} +: 8] = sub_byte;
      next_word = sub_word;
`ifdef AES_KEYEXP_EN
      if (rot_q && (cnt == 2'd3)) begin
         next_word[31:24] = sub_word[31:24] ^ rcon_q;
      end
`endif
   end

   // Select the word latched on an accepted start (RotWord when enabled).
   always_comb begin
      load_word = word_in;
`ifdef AES_KEYEXP_EN
      if (op_rot) begin
         load_word = {word_in[23:0], word_in[31:24]};
      end
`endif
   end

   // Sequencer: IDLE -> SUB (four byte edges) -> DONE (one w cycle) -> IDLE.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values, independent of statement order.
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= 2'd0;
         result <= 32'h0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  result <= load_word;
                  cnt    <= 2'd0;
                  state  <= ST_SUB;
               end
            end
            ST_SUB: begin
               result <= next_word;
               cnt    <= cnt + 2'd1;
               if (cnt == 2'd3) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef AES_KEYEXP_EN
   // Capture the operation form and round constant at acceptance so later
   // changes on op_rot / rcon_in cannot disturb an operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rot_q  <= 1'b0;
         rcon_q <= 8'h00;
      end else if ((state == ST_IDLE) && start) begin
         rot_q  <= op_rot;
         rcon_q <= rcon_in;
      end
   end
`endif

endmodule

// File: tb/tb_aes_subword_ise.sv
// Self-checking bench for aes_subword_ise. Expected words come from an
// independent S-box model built from GF(2^8) inversion plus the affine map,
// queued at start and compared whenever the DUT raises w.

module tb_aes_subword_ise;

   logic        clk;
   logic        rst;
   logic        start;
   logic        op_rot;
   logic [31:0] word_in;
   logic [7:0]  rcon_in;
   logic [7:0]  sr;
   logic [7:0]  sr_out;
   logic [31:0] result;
   logic        busy;
   logic        w;

`ifdef AES_KEYEXP_EN
   localparam bit KEYEXP = 1'b1;
`else
   localparam bit KEYEXP = 1'b0;
`endif

   int          n_cmp;
   int          n_bad;
   int          w_count;
   logic [31:0] exp_q[$];
   logic [7:0]  sbox_m[256];
   logic [7:0]  inv_m[256];

   aes_subword_ise dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op_rot  (op_rot),
      .word_in (word_in),
      .rcon_in (rcon_in),
      .sr      (sr),
      .sr_out  (sr_out),
      .result  (result),
      .busy    (busy),
      .w       (w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = xtime(x);
         y = {1'b0, y[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] d;
      d = {b, b} << n;
      return d[15:8];
   endfunction

   function automatic void build_model();
      logic [7:0] inv;
      logic [7:0] s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
         sbox_m[x] = s;
         inv_m[s]  = 8'(x);
      end
   endfunction

   function automatic logic [31:0] exp_word(input logic [31:0] wd, input logic rot,
                                            input logic [7:0] rc);
      logic [31:0] t;
      logic [31:0] r;
      t = (KEYEXP && rot) ? {wd[23:0], wd[31:24]} : wd;
      for (int b = 0; b < 4; b++) r[b*8 +: 8] = sbox_m[t[b*8 +: 8]];
      if (KEYEXP && rot) r[31:24] = r[31:24] ^ rc;
      return r;
   endfunction

   // Scoreboard: every w pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (w === 1'b1) begin
         logic [31:0] e;
         w_count++;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_w: result=%h, no request outstanding", result);
         end else begin
            e = exp_q.pop_front();
            if (result !== e) begin
               n_bad++;
               $display("FAIL result: got %h, expected %h", result, e);
            end
         end
      end
   end

   // Present one request; returns 1ns after the accepting edge.
   task automatic start_op(input logic [31:0] wd, input logic rot, input logic [7:0] rc,
                           input logic [31:0] expected);
      @(posedge clk);
      #1;
      start   = 1'b1;
      word_in = wd;
      op_rot  = rot;
      rcon_in = rc;
      exp_q.push_back(expected);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while ((busy !== 1'b0 || exp_q.size() != 0) && k < 40) begin
         @(negedge clk);
         k++;
      end
      n_cmp++;
      if (k >= 40) begin
         n_bad++;
         $display("FAIL idle_timeout: busy=%b pending=%0d after %0d cycles", busy, exp_q.size(), k);
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      int wc0;
      #1;
      n_cmp++;
      if (result !== 32'h0 || busy !== 1'b0 || w !== 1'b0 || sr_out !== 8'hA5) begin
         n_bad++;
         $display("FAIL reset_values: result=%h busy=%b w=%b sr_out=%h, expected 0/0/0/a5",
                  result, busy, w, sr_out);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      start_op(32'h03020100, 1'b0, 8'h00, exp_word(32'h03020100, 1'b0, 8'h00));
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      exp_q.delete();
      n_cmp++;
      if (result !== 32'h0 || busy !== 1'b0 || w !== 1'b0 || sr_out !== 8'hA5) begin
         n_bad++;
         $display("FAIL reset_mid_sub: result=%h busy=%b w=%b sr_out=%h, expected 0/0/0/a5",
                  result, busy, w, sr_out);
      end
      wc0 = w_count;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      n_cmp++;
      if (w_count != wc0) begin
         n_bad++;
         $display("FAIL aborted_w: got %0d pulses, expected 0", w_count - wc0);
      end
   endtask

   task automatic test_reset_start();
      @(negedge clk);
      rst     = 1'b1;
      start   = 1'b1;
      word_in = 32'h0F0E0D0C;
      op_rot  = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back(exp_word(32'h0F0E0D0C, 1'b0, 8'h00));
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL start_after_reset: busy=%b, expected 1", busy);
      end
      wait_idle();
   endtask

   task automatic test_subword();
      start_op(32'h03020100, 1'b0, 8'h00, 32'h7B777C63);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_cmp++;
         if (w !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL timing_sub%0d: w=%b busy=%b, expected 0/1", k, w, busy);
         end
      end
      @(negedge clk);
      n_cmp++;
      if (w !== 1'b1 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL timing_done: w=%b busy=%b, expected 1/1", w, busy);
      end
      @(negedge clk);
      n_cmp++;
      if (w !== 1'b0 || busy !== 1'b0 || result !== 32'h7B777C63) begin
         n_bad++;
         $display("FAIL after_done: w=%b busy=%b result=%h, expected 0/0/7b777c63",
                  w, busy, result);
      end
      wait_idle();
   endtask

   task automatic test_keyexp();
      logic [31:0] wd;
      logic [7:0]  rc;
      start_op(32'h09CF4F3C, 1'b1, 8'h01, KEYEXP ? 32'h8B84EB01 : 32'h018A84EB);
      word_in = 32'hFFFFFFFF;
      rcon_in = 8'hFF;
      op_rot  = 1'b0;
      wait_idle();
      for (int i = 0; i < 4; i++) begin
         wd = $urandom;
         rc = 8'($urandom_range(1, 255));
         start_op(wd, 1'b1, rc, exp_word(wd, 1'b1, rc));
         wait_idle();
      end
   endtask

   task automatic test_busy_reject();
      int wc0;
      wc0 = w_count;
      start_op(32'h11223344, 1'b0, 8'h00, exp_word(32'h11223344, 1'b0, 8'h00));
      @(posedge clk);
      #1;
      start   = 1'b1;
      word_in = 32'hAABBCCDD;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      start   = 1'b1;
      word_in = 32'h55667788;
      @(posedge clk);
      #1;
      word_in = 32'h99A0B1C2;
      exp_q.push_back(exp_word(32'h99A0B1C2, 1'b0, 8'h00));
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_idle();
      n_cmp++;
      if (w_count - wc0 != 2) begin
         n_bad++;
         $display("FAIL busy_reject_count: got %0d pulses, expected 2", w_count - wc0);
      end
   endtask

   task automatic test_back_to_back();
      int wc0;
      wc0 = w_count;
      @(posedge clk);
      #1;
      start   = 1'b1;
      word_in = 32'hDEADBEEF;
      op_rot  = 1'b0;
      exp_q.push_back(exp_word(32'hDEADBEEF, 1'b0, 8'h00));
      exp_q.push_back(exp_word(32'hDEADBEEF, 1'b0, 8'h00));
      repeat (7) @(posedge clk);
      #1;
      start = 1'b0;
      wait_idle();
      n_cmp++;
      if (w_count - wc0 != 2) begin
         n_bad++;
         $display("FAIL back_to_back_count: got %0d pulses, expected 2", w_count - wc0);
      end
   endtask

   task automatic test_sbox_sweep();
      logic [31:0] wd;
      int k;
      for (int i = 0; i < 64; i++) begin
         wd = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
         start_op(wd, 1'b0, 8'h00, exp_word(wd, 1'b0, 8'h00));
         k = 0;
         while (w !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
         end
         n_cmp++;
         if (w !== 1'b1) begin
            n_bad++;
            $display("FAIL sweep_timeout: op %0d produced no w", i);
         end else begin
            for (int b = 0; b < 4; b++) begin
               if (inv_m[result[b*8 +: 8]] !== wd[b*8 +: 8]) begin
                  n_bad++;
                  $display("FAIL sweep_inverse: byte %h maps to %h, inverse gives %h",
                           wd[b*8 +: 8], result[b*8 +: 8], inv_m[result[b*8 +: 8]]);
               end
            end
         end
         wait_idle();
      end
   endtask

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      w_count = 0;
      rst     = 1'b1;
      start   = 1'b0;
      op_rot  = 1'b0;
      word_in = 32'h0;
      rcon_in = 8'h0;
      sr      = 8'hA5;
      build_model();
      test_reset();
      test_reset_start();
      test_subword();
      test_keyexp();
      test_busy_reject();
      test_back_to_back();
      test_sbox_sweep();
      n_cmp++;
      if (sr_out !== 8'hA5) begin
         n_bad++;
         $display("FAIL sr_passthrough: got %h, expected a5", sr_out);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
